// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side nibble packer: default sizes, FSM encoding, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int WD_DEF        = 4;
  localparam int NPW_DEF       = 4;
  localparam int FRAME_LEN_DEF = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_PUSH = 2'd2
  } state_e;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/word_skid_buf.sv
// Two-entry {data,last} word buffer between the packer and the output stream.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push is dropped only when full without a same-cycle pop; caller never does that.
module word_skid_buf #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          head_last_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] d0_q, d1_q;
  logic          l0_q, l1_q;
  logic [1:0]    occ_q;
  logic          pop_eff, push_eff;
  logic [1:0]    wr_idx;

  assign pop_eff  = pop_i && (occ_q != 2'd0);
  assign push_eff = push_i && ((occ_q != 2'd2) || pop_eff);
  // Slot the new word lands in, after any same-cycle shift from a pop.
  assign wr_idx   = occ_q - {1'b0, pop_eff};

  // Shift on pop, then write the incoming word into the first free slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (pop_eff) begin
        d0_q <= d1_q;
        l0_q <= l1_q;
      end
      if (push_eff && (wr_idx == 2'd0)) begin
        d0_q <= push_data_i;
        l0_q <= push_last_i;
      end
      if (push_eff && (wr_idx == 2'd1)) begin
        d1_q <= push_data_i;
        l1_q <= push_last_i;
      end
      occ_q <= occ_q + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  assign head_data_o = d0_q;
  assign head_last_o = l0_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops nibbles from the async FIFO read port, packs NPW per word, tags frame ends, supports flush.
// Latency: word appears one cycle after its last nibble lands (two cycles after that nibble's read).
// Backpressure: reads throttle on registered buffer occupancy so a landing nibble never overflows it.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WD        = WD_DEF,
  parameter int NPW       = NPW_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WD-1:0]     fifo_rdata,
  input  logic              fifo_rdata_valid,
  input  logic              flush,
  output logic [WD*NPW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err_unexp
);

  localparam int OW  = WD * NPW;
  localparam int NCW = cw(NPW);
  localparam int FCW = cw(FRAME_LEN);
  localparam logic [NCW:0]   NPW_W   = (NCW+1)'(NPW);
  localparam logic [NCW:0]   ONE_W   = (NCW+1)'(1);
  localparam logic [NCW-1:0] NIB_MAX = NCW'(NPW - 1);
  localparam logic [FCW-1:0] FRM_MAX = FCW'(FRAME_LEN - 1);

  state_e         state_q;
  logic [NCW-1:0] nib_cnt_q;
  logic           inflight_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [OW-1:0]  asm_q, asm_d;
  logic           err_q;

  logic [1:0]     occ;
  logic [NCW:0]   n_cnt;
  logic           take, word_done, frame_end, flush_go;
  logic           push, push_last, pop;

  // Nibbles already held plus the one still on its way back from the FIFO.
  assign n_cnt = {1'b0, nib_cnt_q} + {{NCW{1'b0}}, inflight_q};

  // With one word buffered, only read if this nibble cannot complete a second word.
  assign fifo_rd_en = !rst && (state_q == RUN) && !fifo_empty &&
                      ((occ == 2'd0) || ((occ == 2'd1) && ((n_cnt + ONE_W) < NPW_W)));

  assign take      = fifo_rdata_valid && inflight_q;
  assign word_done = take && (nib_cnt_q == NIB_MAX);
  assign frame_end = (frame_cnt_q == FRM_MAX);
  assign flush_go  = (state_q == FLUSH_PUSH) && (occ != 2'd2);
  assign push      = word_done || flush_go;
  assign push_last = word_done ? frame_end : 1'b1;
  assign pop       = out_valid && out_ready;

  // Assembly word with the landing nibble merged into its slot; upper slots stay zero.
  always_comb begin
    asm_d = asm_q;
    if (take) asm_d[nib_cnt_q*WD +: WD] = fifo_rdata;
  end

  // Read tracking, nibble packing, frame counting and the flush FSM.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      nib_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      frame_cnt_q <= '0;
      asm_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (fifo_rd_en)            inflight_q <= 1'b1;
      else if (fifo_rdata_valid) inflight_q <= 1'b0;

      if (fifo_rdata_valid && !inflight_q) err_q <= 1'b1;

      if (take) begin
        if (word_done) begin
          asm_q       <= '0;
          nib_cnt_q   <= '0;
          frame_cnt_q <= frame_end ? '0 : frame_cnt_q + FCW'(1);
        end else begin
          asm_q     <= asm_d;
          nib_cnt_q <= nib_cnt_q + NCW'(1);
        end
      end

      case (state_q)
        RUN: if (flush) state_q <= FLUSH_WAIT;
        FLUSH_WAIT: begin
          if (!inflight_q) begin
            if (nib_cnt_q == '0) begin
              frame_cnt_q <= '0;
              state_q     <= RUN;
            end else begin
              state_q <= FLUSH_PUSH;
            end
          end
        end
        FLUSH_PUSH: begin
          if (flush_go) begin
            asm_q       <= '0;
            nib_cnt_q   <= '0;
            frame_cnt_q <= '0;
            state_q     <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  word_skid_buf #(.DW(OW)) u_obuf (
    .clk_i       (rclk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (asm_d),
    .push_last_i (push_last),
    .pop_i       (pop),
    .head_data_o (out_data),
    .head_last_o (out_last),
    .occ_o       (occ)
  );

  assign out_valid = (occ != 2'd0);
  assign busy      = (state_q != RUN);
  assign err_unexp = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO read-port model, nibble-packing reference model, word scoreboard.
// Latency: FIFO model returns read data one cycle after an accepted fifo_rd_en.
// Backpressure: out_ready driven per scenario.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int WD = 4, NPW = 4, FRAME_LEN = 8, OW = WD * NPW;

  logic          rclk = 1'b0;
  logic          rst, fifo_empty, fifo_rd_en, fifo_rdata_valid, flush;
  logic          out_valid, out_ready, out_last, busy, err_unexp;
  logic [WD-1:0] fifo_rdata;
  logic [OW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [WD-1:0] mq[$];   // contents of the modelled FIFO
  logic [OW:0]   sb[$];   // expected {last, data} words
  logic [OW-1:0] m_asm;
  int            m_nib, m_frame;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.WD(WD), .NPW(NPW), .FRAME_LEN(FRAME_LEN)) dut (
    .rclk(rclk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .fifo_rdata_valid(fifo_rdata_valid), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_unexp(err_unexp)
  );

  // Queue a nibble in the FIFO and advance the reference packer.
  task automatic feed(input logic [WD-1:0] n);
    mq.push_back(n);
    fifo_empty = 1'b0;
    m_asm[m_nib*WD +: WD] = n;
    m_nib++;
    if (m_nib == NPW) begin
      sb.push_back({(m_frame == FRAME_LEN - 1), m_asm});
      m_asm   = '0;
      m_nib   = 0;
      m_frame = (m_frame + 1) % FRAME_LEN;
    end
  endtask

  task automatic model_flush();
    if (m_nib != 0) sb.push_back({1'b1, m_asm});
    m_asm   = '0;
    m_nib   = 0;
    m_frame = 0;
  endtask

  task automatic model_clear();
    sb.delete();
    mq.delete();
    m_asm   = '0;
    m_nib   = 0;
    m_frame = 0;
  endtask

  // One clock: starts and ends at a falling edge. Checks outputs before the rising edge,
  // then plays the FIFO read port for the following cycle.
  task automatic step(input bit spur = 1'b0);
    logic        fire;
    logic [OW:0] exp_w;
    #1;
    fire = fifo_rd_en;
    checks++;
    if (fifo_rd_en && fifo_empty) begin
      errors++;
      $display("FAIL rd_en_while_empty: fifo_rd_en=%0b with fifo_empty=%0b, required fifo_rd_en=0", fifo_rd_en, fifo_empty);
    end
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h last=%0b, no word expected", out_data, out_last);
      end else begin
        exp_w = sb.pop_front();
        if ({out_last, out_data} !== exp_w) begin
          errors++;
          $display("FAIL word: got data=%h last=%0b, required data=%h last=%0b", out_data, out_last, exp_w[OW-1:0], exp_w[OW]);
        end
      end
    end
    @(posedge rclk);
    #1;
    flush = 1'b0;
    fifo_rdata_valid = fire | spur;
    if (fire && mq.size() > 0) fifo_rdata = mq.pop_front();
    else if (spur) fifo_rdata = 4'hF;
    fifo_empty = (mq.size() == 0);
    @(negedge rclk);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k = 0;
    while ((sb.size() != 0 || mq.size() != 0 || out_valid) && k < max_cyc) begin
      step();
      k++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, out_valid=%0b after %0d cycles, required 0 and 0", tag, sb.size(), out_valid, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b1; fifo_rdata_valid = 1'b0; fifo_rdata = '0;
    flush = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge rclk);
    #1;
    checks++;
    if ({fifo_rd_en, out_valid, out_last, busy, err_unexp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: rd_en,valid,last,busy,err=%b, required 00000", {fifo_rd_en, out_valid, out_last, busy, err_unexp});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: out_data=%h, required 0000", out_data);
    end
    fifo_empty = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en: fifo_rd_en=%0b with FIFO non-empty in reset, required 0", fifo_rd_en);
    end
    fifo_empty = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) feed(4'(i));
    drain("stream", 100);
  endtask

  task automatic test_flush_empty();
    int k = 0;
    flush = 1'b1;
    model_flush();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty_busy: busy=%0b, required 1", busy);
    end
    while (busy && k < 2) begin
      step();
      k++;
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_idle: busy=%0b out_valid=%0b, required 0 and 0", busy, out_valid);
    end
  endtask

  task automatic test_frame();
    for (int i = 0; i < 36; i++) feed(4'((i * 7 + 3) % 16));
    drain("frame", 300);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) feed(4'(15 - i));
    repeat (40) step();
    checks++;
    if (fifo_rd_en !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: fifo_rd_en=%0b out_valid=%0b, required 0 and 1", fifo_rd_en, out_valid);
    end
    checks++;
    if (mq.size() != 9) begin
      errors++;
      $display("FAIL bp_consumed: %0d nibbles left in FIFO, required 9", mq.size());
    end
    out_ready = 1'b1;
    drain("backpressure", 200);
  endtask

  task automatic test_flush_partial();
    feed(4'hA);
    feed(4'hB);
    repeat (6) step();
    flush = 1'b1;
    model_flush();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial_busy: busy=%0b, required 1", busy);
    end
    drain("flush_partial", 50);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_partial_done: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_flush_inflight();
    feed(4'h5);
    flush = 1'b1;
    model_flush();
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle_rd: fifo_rd_en=%0b, required 1", fifo_rd_en);
    end
    step();
    drain("flush_inflight", 50);
    // Frame counter must have restarted: last appears on the FRAME_LEN-th word only.
    for (int i = 0; i < 32; i++) feed(4'(i % 16));
    drain("frame_restart", 300);
  endtask

  task automatic test_spurious();
    step(1'b1);
    step();
    checks++;
    if (err_unexp !== 1'b1) begin
      errors++;
      $display("FAIL spurious_err: err_unexp=%0b, required 1", err_unexp);
    end
    repeat (3) step();
    checks++;
    if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_sticky: err_unexp=%0b out_valid=%0b, required 1 and 0", err_unexp, out_valid);
    end
    feed(4'h9); feed(4'h8); feed(4'h7); feed(4'h6);
    drain("spurious", 100);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) feed(4'(i + 8));
    repeat (12) step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%0b, required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, out_valid, out_last, busy, err_unexp} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async: rd_en,valid,last,busy,err=%b data=%h, required 00000 and 0000", {fifo_rd_en, out_valid, out_last, busy, err_unexp}, out_data);
    end
    model_clear();
    fifo_empty = 1'b1;
    fifo_rdata_valid = 1'b0;
    @(negedge rclk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) feed(4'(i));
    drain("rstmid", 100);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush_empty();
    test_frame();
    test_backpressure();
    test_flush_partial();
    test_flush_inflight();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
